// File: rtl/perf_event_counter.sv
// Performance-monitor counters for the WISC-S15 core: one cycle counter plus
// NUM_EVENTS level/edge event channels, freeze on HALT, registered read port.
module perf_event_counter #(
    parameter int unsigned           NUM_EVENTS = 6,
    parameter int unsigned           CNT_WIDTH  = 32,
    parameter int unsigned           SATURATE   = 1,
    parameter logic [NUM_EVENTS-1:0] EDGE_MASK  = 6'b110000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  hlt,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  rd_en,
    input  logic [3:0]            rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic                  rd_valid,
    output logic [NUM_EVENTS:0]   ovf,
    output logic [1:0]            state_o
);

    localparam int unsigned NCNT = NUM_EVENTS + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        FROZEN   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_WIDTH-1:0]  r_cnt [NCNT];
    logic [NCNT-1:0]       r_ovf;
    logic [NCNT-1:0]       w_inc;
    logic [NUM_EVENTS-1:0] r_prev;
    logic                  w_count_en;
    logic [CNT_WIDTH-1:0]  w_rd_mux;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (hlt)        w_next = FROZEN;
                else if (start) w_next = COUNTING;
            end
            COUNTING: if (hlt) w_next = FROZEN;
            FROZEN:   w_next = FROZEN;
            default:  w_next = IDLE;
        endcase
        if (clear) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Index 0 is the cycle counter; index i+1 is event channel i.
    always_comb begin
        w_count_en = (r_state == COUNTING) && !hlt;
        w_inc      = '0;
        w_inc[0]   = w_count_en;
        for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
            w_inc[i+1] = w_count_en && event_in[i] && !(EDGE_MASK[i] && r_prev[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int unsigned i = 0; i < NCNT; i++) r_cnt[i] <= '0;
            r_ovf <= '0;
        end else begin
            for (int unsigned i = 0; i < NCNT; i++) begin
                if (w_inc[i]) begin
                    if (&r_cnt[i]) begin
                        r_ovf[i] <= 1'b1;
                        if (SATURATE == 0) r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Edge history is cleared only by rst, so a level held across clear is not recounted.
    always_ff @(posedge clk) begin
        if (rst) r_prev <= '0;
        else     r_prev <= event_in;
    end

    always_comb begin
        w_rd_mux = '0;
        for (int unsigned i = 0; i < NCNT; i++) begin
            if (32'(rd_sel) == i) w_rd_mux = r_cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= w_rd_mux;
        end
    end

    assign ovf     = r_ovf;
    assign state_o = r_state;

endmodule

// File: tb/tb_perf_event_counter.sv
// Self-checking bench: three perf_event_counter variants (32-bit, 8-bit
// saturating, 8-bit wrapping) share stimulus and are checked against a model.
module tb_perf_event_counter;

    localparam logic [5:0] EMASK = 6'b110000;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, clear = 1'b0, hlt = 1'b0;
    logic [5:0]  event_in = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_sel = '0;

    logic [31:0] rd_data_m;
    logic [7:0]  rd_data_s, rd_data_w;
    logic        rd_valid_m, rd_valid_s, rd_valid_w;
    logic [6:0]  ovf_m, ovf_s, ovf_w;
    logic [1:0]  state_m, state_s, state_w;

    int n_checks = 0;
    int n_errors = 0;

    // Model: true (unbounded) event totals since last clear/reset.
    longint      m_true [7];
    logic [5:0]  m_prev;
    int          m_state;
    logic        m_rv;
    logic [31:0] m_rd [3];

    always #5 clk = ~clk;

    perf_event_counter #(.NUM_EVENTS(6), .CNT_WIDTH(32), .SATURATE(1), .EDGE_MASK(EMASK)) dut_m (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .hlt(hlt), .event_in(event_in),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_m), .rd_valid(rd_valid_m),
        .ovf(ovf_m), .state_o(state_m));

    perf_event_counter #(.NUM_EVENTS(6), .CNT_WIDTH(8), .SATURATE(1), .EDGE_MASK(EMASK)) dut_s (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .hlt(hlt), .event_in(event_in),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_s), .rd_valid(rd_valid_s),
        .ovf(ovf_s), .state_o(state_s));

    perf_event_counter #(.NUM_EVENTS(6), .CNT_WIDTH(8), .SATURATE(0), .EDGE_MASK(EMASK)) dut_w (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .hlt(hlt), .event_in(event_in),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_w), .rd_valid(rd_valid_w),
        .ovf(ovf_w), .state_o(state_w));

    // kind 0: 32-bit; 1: 8-bit saturating; 2: 8-bit wrapping
    function automatic logic [31:0] exp_val(int kind, longint t);
        if (kind == 0) return 32'(t);
        if (kind == 1) return (t > 255) ? 32'd255 : 32'(t);
        return 32'(t % 256);
    endfunction

    function automatic logic [6:0] exp_ovf(int kind);
        logic [6:0] v;
        for (int i = 0; i < 7; i++)
            v[i] = (kind == 0) ? (m_true[i] > 64'h0000_0000_FFFF_FFFF) : (m_true[i] > 255);
        return v;
    endfunction

    // Advance model by one clock using current inputs, then cross the edge.
    task automatic step();
        if (rst) begin
            for (int i = 0; i < 7; i++) m_true[i] = 0;
            m_state = 0;
            m_rv    = 1'b0;
            for (int k = 0; k < 3; k++) m_rd[k] = '0;
        end else begin
            m_rv = rd_en;
            if (rd_en)
                for (int k = 0; k < 3; k++)
                    m_rd[k] = (rd_sel > 6) ? 32'd0 : exp_val(k, m_true[rd_sel]);
            if (clear) begin
                for (int i = 0; i < 7; i++) m_true[i] = 0;
                m_state = 0;
            end else begin
                if (m_state == 1 && !hlt) begin
                    m_true[0]++;
                    for (int i = 0; i < 6; i++)
                        if (event_in[i] && !(EMASK[i] && m_prev[i])) m_true[i+1]++;
                end
                if (m_state == 0)               m_state = hlt ? 2 : (start ? 1 : 0);
                else if (m_state == 1 && hlt)   m_state = 2;
            end
        end
        m_prev = rst ? 6'd0 : event_in;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] sel);
        rd_en = 1'b1; rd_sel = sel;
        step();
        rd_en = 1'b0;
    endtask

    task automatic restart();
        clear = 1'b1; step(); clear = 1'b0;
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
        n_checks++; if (state_m !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d exp 0", state_m); end
        n_checks++; if (ovf_m !== 7'd0 || ovf_s !== 7'd0 || ovf_w !== 7'd0) begin n_errors++; $display("FAIL reset_ovf: got %h/%h/%h exp 0", ovf_m, ovf_s, ovf_w); end
        for (int s = 0; s < 7; s++) begin
            do_read(4'(s));
            n_checks++; if (rd_valid_m !== 1'b1) begin n_errors++; $display("FAIL reset_rd_valid sel%0d: got %b exp 1", s, rd_valid_m); end
            n_checks++; if (rd_data_m !== 32'd0 || rd_data_s !== 8'd0 || rd_data_w !== 8'd0) begin n_errors++; $display("FAIL reset_rd_data sel%0d: got %0d/%0d/%0d exp 0", s, rd_data_m, rd_data_s, rd_data_w); end
        end
    endtask

    task automatic test_cycle_freeze();
        restart();
        repeat (10) step();
        hlt = 1'b1; step(); hlt = 1'b0;
        do_read(4'd0);
        n_checks++; if (rd_data_m !== 32'd10 || rd_data_s !== 8'd10) begin n_errors++; $display("FAIL freeze_cycles: got %0d/%0d exp 10", rd_data_m, rd_data_s); end
        n_checks++; if (state_m !== 2'd2) begin n_errors++; $display("FAIL freeze_state: got %0d exp 2", state_m); end
        repeat (5) step();
        do_read(4'd0);
        n_checks++; if (rd_data_m !== 32'd10 || rd_data_w !== 8'd10) begin n_errors++; $display("FAIL freeze_hold: got %0d/%0d exp 10", rd_data_m, rd_data_w); end
    endtask

    task automatic test_level_edge();
        restart();
        event_in = 6'b010001; repeat (4) step();
        event_in = '0; step();
        repeat (3) begin event_in = 6'b100000; step(); event_in = '0; step(); end
        hlt = 1'b1; step(); hlt = 1'b0;
        do_read(4'd1);
        n_checks++; if (rd_data_m !== 32'd4) begin n_errors++; $display("FAIL level_ch0: got %0d exp 4", rd_data_m); end
        do_read(4'd5);
        n_checks++; if (rd_data_m !== 32'd1) begin n_errors++; $display("FAIL edge_ch4: got %0d exp 1", rd_data_m); end
        do_read(4'd6);
        n_checks++; if (rd_data_m !== 32'd3 || rd_data_w !== 8'd3) begin n_errors++; $display("FAIL edge_ch5: got %0d/%0d exp 3", rd_data_m, rd_data_w); end
    endtask

    task automatic test_overflow();
        restart();
        event_in = 6'b000001; repeat (300) step();
        event_in = '0; hlt = 1'b1; step(); hlt = 1'b0;
        do_read(4'd1);
        n_checks++; if (rd_data_m !== 32'd300) begin n_errors++; $display("FAIL ovf_wide: got %0d exp 300", rd_data_m); end
        n_checks++; if (rd_data_s !== 8'd255) begin n_errors++; $display("FAIL ovf_sat: got %0d exp 255", rd_data_s); end
        n_checks++; if (rd_data_w !== 8'd44) begin n_errors++; $display("FAIL ovf_wrap: got %0d exp 44", rd_data_w); end
        n_checks++; if (ovf_s[1] !== 1'b1 || ovf_w[1] !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b/%b exp 1/1", ovf_s[1], ovf_w[1]); end
        n_checks++; if (ovf_m !== 7'd0) begin n_errors++; $display("FAIL ovf_none_wide: got %b exp 0", ovf_m); end
        repeat (3) step();
        n_checks++; if (ovf_s[1] !== 1'b1 || ovf_w[0] !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b/%b exp 1/1", ovf_s[1], ovf_w[0]); end
    endtask

    task automatic test_priority();
        restart();
        event_in = 6'b001111; repeat (5) step();
        clear = 1'b1; hlt = 1'b1; step(); clear = 1'b0; hlt = 1'b0; event_in = '0;
        n_checks++; if (state_m !== 2'd0) begin n_errors++; $display("FAIL prio_clear_state: got %0d exp 0", state_m); end
        n_checks++; if (ovf_s !== 7'd0) begin n_errors++; $display("FAIL prio_clear_ovf: got %b exp 0", ovf_s); end
        for (int s = 0; s < 7; s++) begin
            do_read(4'(s));
            n_checks++; if (rd_data_m !== 32'd0) begin n_errors++; $display("FAIL prio_clear_cnt sel%0d: got %0d exp 0", s, rd_data_m); end
        end
        start = 1'b1; hlt = 1'b1; event_in = 6'b111111; step(); start = 1'b0; hlt = 1'b0;
        n_checks++; if (state_m !== 2'd2) begin n_errors++; $display("FAIL prio_start_hlt_state: got %0d exp 2", state_m); end
        repeat (3) step();
        do_read(4'd0);
        n_checks++; if (rd_data_m !== 32'd0) begin n_errors++; $display("FAIL prio_frozen_cycles: got %0d exp 0", rd_data_m); end
        do_read(4'd1);
        n_checks++; if (rd_data_m !== 32'd0) begin n_errors++; $display("FAIL prio_frozen_ch0: got %0d exp 0", rd_data_m); end
        event_in = '0;
    endtask

    task automatic test_reads();
        restart();
        repeat (7) step();
        hlt = 1'b1; step(); hlt = 1'b0;
        rd_en = 1'b1; rd_sel = 4'd0; clear = 1'b1; step(); rd_en = 1'b0; clear = 1'b0;
        n_checks++; if (rd_data_m !== 32'd7 || rd_valid_m !== 1'b1) begin n_errors++; $display("FAIL read_preclear: got %0d v%b exp 7 v1", rd_data_m, rd_valid_m); end
        n_checks++; if (state_m !== 2'd0) begin n_errors++; $display("FAIL read_clear_state: got %0d exp 0", state_m); end
        step();
        n_checks++; if (rd_valid_m !== 1'b0 || rd_data_m !== 32'd7) begin n_errors++; $display("FAIL read_hold: got %0d v%b exp 7 v0", rd_data_m, rd_valid_m); end
        do_read(4'd0);
        n_checks++; if (rd_data_m !== 32'd0) begin n_errors++; $display("FAIL read_postclear: got %0d exp 0", rd_data_m); end
        do_read(4'd9);
        n_checks++; if (rd_valid_m !== 1'b1 || rd_data_m !== 32'd0 || rd_data_s !== 8'd0) begin n_errors++; $display("FAIL read_oob: got %0d v%b exp 0 v1", rd_data_m, rd_valid_m); end
        start = 1'b1; step(); start = 1'b0;
        event_in = 6'b000011; repeat (6) step();
        rst = 1'b1; step(); rst = 1'b0; event_in = '0;
        n_checks++; if (state_m !== 2'd0 || rd_valid_m !== 1'b0 || rd_data_m !== 32'd0) begin n_errors++; $display("FAIL rst_mid: got st%0d v%b d%0d exp st0 v0 d0", state_m, rd_valid_m, rd_data_m); end
        for (int s = 0; s < 3; s++) begin
            do_read(4'(s));
            n_checks++; if (rd_data_m !== 32'd0) begin n_errors++; $display("FAIL rst_mid_cnt sel%0d: got %0d exp 0", s, rd_data_m); end
        end
    endtask

    task automatic test_random();
        restart();
        for (int n = 0; n < 400; n++) begin
            event_in = 6'($urandom);
            rd_en    = ($urandom_range(0, 3) != 0);
            rd_sel   = 4'($urandom_range(0, 9));
            hlt      = ($urandom_range(0, 40) == 0);
            clear    = ($urandom_range(0, 60) == 0);
            start    = ($urandom_range(0, 8) == 0);
            step();
            n_checks++; if (state_m !== 2'(m_state) || state_s !== 2'(m_state) || state_w !== 2'(m_state)) begin n_errors++; $display("FAIL rand_state @%0d: got %0d/%0d/%0d exp %0d", n, state_m, state_s, state_w, m_state); end
            n_checks++; if (rd_valid_m !== m_rv || rd_valid_s !== m_rv || rd_valid_w !== m_rv) begin n_errors++; $display("FAIL rand_valid @%0d: got %b/%b/%b exp %b", n, rd_valid_m, rd_valid_s, rd_valid_w, m_rv); end
            n_checks++; if (rd_data_m !== m_rd[0]) begin n_errors++; $display("FAIL rand_data_wide @%0d: got %0d exp %0d", n, rd_data_m, m_rd[0]); end
            n_checks++; if (rd_data_s !== m_rd[1][7:0]) begin n_errors++; $display("FAIL rand_data_sat @%0d: got %0d exp %0d", n, rd_data_s, m_rd[1][7:0]); end
            n_checks++; if (rd_data_w !== m_rd[2][7:0]) begin n_errors++; $display("FAIL rand_data_wrap @%0d: got %0d exp %0d", n, rd_data_w, m_rd[2][7:0]); end
            n_checks++; if (ovf_m !== exp_ovf(0) || ovf_s !== exp_ovf(1) || ovf_w !== exp_ovf(2)) begin n_errors++; $display("FAIL rand_ovf @%0d: got %b/%b/%b exp %b/%b/%b", n, ovf_m, ovf_s, ovf_w, exp_ovf(0), exp_ovf(1), exp_ovf(2)); end
        end
        event_in = '0; rd_en = 1'b0; hlt = 1'b0; clear = 1'b0; start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cycle_freeze();
        test_level_edge();
        test_overflow();
        test_priority();
        test_reads();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
